// File: rtl/bus_control_unit_pkg.sv
// Shared types for the v30mz bus control unit: EU command encoding,
// external bus status codes and the BCU state machine states.
package v30mz_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE      = 3'd0,
        CMD_MEM_READ  = 3'd1,
        CMD_MEM_WRITE = 3'd2,
        CMD_IO_READ   = 3'd3,
        CMD_IO_WRITE  = 3'd4
    } bus_command_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_EU_ACCESS,
        ST_FLUSH_DRAIN
    } bcu_state_t;

    localparam logic [3:0] BUS_STATUS_IDLE      = 4'b1111;
    localparam logic [3:0] BUS_STATUS_MEM_READ  = 4'b1001;
    localparam logic [3:0] BUS_STATUS_MEM_WRITE = 4'b1010;
    localparam logic [3:0] BUS_STATUS_IO_READ   = 4'b0101;
    localparam logic [3:0] BUS_STATUS_IO_WRITE  = 4'b0110;

    function automatic logic [3:0] cmd_status(bus_command_t cmd);
        case (cmd)
            CMD_MEM_READ:  return BUS_STATUS_MEM_READ;
            CMD_MEM_WRITE: return BUS_STATUS_MEM_WRITE;
            CMD_IO_READ:   return BUS_STATUS_IO_READ;
            CMD_IO_WRITE:  return BUS_STATUS_IO_WRITE;
            default:       return BUS_STATUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bus_control_unit_if.sv
// External bus pins of the BCU. master = BCU side, slave = memory/IO side.
interface bus_control_unit_if;
    logic [19:0] address_out;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [3:0]  bus_status;
    logic        bus_upper_byte_enable;
    logic        readyb;

    modport master (
        output address_out, data_out, bus_status, bus_upper_byte_enable,
        input  data_in, readyb
    );

    modport slave (
        input  address_out, data_out, bus_status, bus_upper_byte_enable,
        output data_in, readyb
    );
endinterface

// File: rtl/bus_control_unit_prefetch_fifo.sv
// Byte-wide prefetch queue: 0/1/2-byte push (low byte first), 1-byte pop,
// synchronous clear that takes priority over push and pop.
module prefetch_fifo #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [1:0]                         push_n,
    input  logic [15:0]                        push_data,
    input  logic                               pop,
    output logic [7:0]                         head,
    output logic                               empty,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    logic [7:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    // A pop against an empty queue is dropped, even if bytes land on the same edge.
    assign do_pop = pop && (cnt != '0);
    assign head   = mem[rd_ptr];
    assign empty  = (cnt == '0);
    assign count  = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt    <= cnt + CW'(push_n) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_n != 2'd0) mem[wr_ptr] <= push_data[7:0];
            if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= push_data[15:8];
        end
    end

endmodule

// File: rtl/bus_control_unit.sv
// v30mz bus control unit: prefetch queue, EU bus commands and external bus FSM.
// Optional BCU_ODD_ALIGN_EN: odd-PFP prefetch is a single upper-lane byte cycle at the odd address.
module bus_control_unit
    import v30mz_pkg::*;
#(
    parameter int QUEUE_DEPTH       = 8,
    parameter int PREFETCH_MIN_FREE = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [15:0]                       ps,
    input  logic                              flush,
    input  logic [15:0]                       flush_pc,
    input  logic                              suspend,
    input  logic                              pop,
    output logic [7:0]                        q_data,
    output logic                              q_empty,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]  q_count,
    input  bus_command_t                      eu_cmd,
    input  logic [19:0]                       eu_addr,
    input  logic [15:0]                       eu_wdata,
    input  logic                              eu_ube,
    output logic [15:0]                       eu_rdata,
    output logic                              eu_done,
    bus_control_unit_if.master                bus
);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    bcu_state_t    state;
    logic [15:0]   pfp;
    logic          cur_odd;
    logic [CW-1:0] free;
    logic          free_ok;
    logic [15:0]   pf_off;
    logic [19:0]   pf_addr;
    logic [1:0]    push_n;
    logic [15:0]   push_data;
    logic          cycle_end;

    assign free    = CW'(QUEUE_DEPTH) - q_count;
    assign free_ok = pfp[0] ? (free != '0) : (free >= CW'(PREFETCH_MIN_FREE));

`ifdef BCU_ODD_ALIGN_EN
    assign pf_off = pfp;
`else
    assign pf_off = {pfp[15:1], 1'b0};
`endif
    // 20-bit physical address; carry out of bit 19 wraps around.
    assign pf_addr   = {ps, 4'h0} + {4'h0, pf_off};
    assign cycle_end = (state != ST_IDLE) && !bus.readyb;

    // Odd fetches deliver the wanted byte on the upper lane in both alignment modes.
    always_comb begin
        push_n    = 2'd0;
        push_data = bus.data_in;
        if (state == ST_PREFETCH && !bus.readyb && !flush) begin
            if (cur_odd) begin
                push_n    = 2'd1;
                push_data = {8'h00, bus.data_in[15:8]};
            end else begin
                push_n    = 2'd2;
            end
        end
    end

    prefetch_fifo #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (pop),
        .head      (q_data),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                     <= ST_IDLE;
            pfp                       <= 16'h0000;
            cur_odd                   <= 1'b0;
            bus.address_out           <= 20'hFFFFF;
            bus.data_out              <= 16'h0000;
            bus.bus_status            <= BUS_STATUS_IDLE;
            bus.bus_upper_byte_enable <= 1'b0;
            eu_rdata                  <= 16'h0000;
            eu_done                   <= 1'b0;
        end else begin
            eu_done <= 1'b0;
            if (flush) pfp <= flush_pc;
            case (state)
                ST_IDLE: begin
                    // EU wins; a flush edge never starts a prefetch with the stale PFP.
                    if (eu_cmd != CMD_IDLE) begin
                        state                     <= ST_EU_ACCESS;
                        bus.address_out           <= eu_addr;
                        bus.data_out              <= eu_wdata;
                        bus.bus_upper_byte_enable <= eu_ube;
                        bus.bus_status            <= cmd_status(eu_cmd);
                    end else if (!flush && !suspend && free_ok) begin
                        state                     <= ST_PREFETCH;
                        bus.address_out           <= pf_addr;
                        bus.bus_upper_byte_enable <= 1'b1;
                        bus.bus_status            <= BUS_STATUS_MEM_READ;
                        cur_odd                   <= pfp[0];
                    end
                end
                ST_PREFETCH: begin
                    if (!bus.readyb && !flush)
                        pfp <= pfp + (cur_odd ? 16'd1 : 16'd2);
                    else if (bus.readyb && flush)
                        state <= ST_FLUSH_DRAIN;
                end
                ST_EU_ACCESS: begin
                    if (!bus.readyb) begin
                        eu_rdata <= bus.data_in;
                        eu_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (cycle_end) begin
                state                     <= ST_IDLE;
                bus.address_out           <= 20'hFFFFF;
                bus.bus_status            <= BUS_STATUS_IDLE;
                bus.bus_upper_byte_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_control_unit.sv
// Scoreboard bench for bus_control_unit: expected bus cycles, queue bytes and EU
// read data are queued by the stimulus and checked by an independent monitor.
module tb_bus_control_unit;
    import v30mz_pkg::*;

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  st;
        logic        ube;
        logic [15:0] wd;
    } bus_rec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  ps, flush_pc, eu_wdata, eu_rdata;
    logic         flush, suspend, pop, eu_ube, eu_done, q_empty;
    logic [19:0]  eu_addr;
    logic [7:0]   q_data;
    logic [3:0]   q_count;
    bus_command_t eu_cmd;
    logic         force_en;
    logic [15:0]  force_val;

    bus_rec_t     bus_q[$];
    logic [7:0]   byte_q[$];
    logic [15:0]  rd_q[$];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    bus_control_unit_if bif();

    // Memory model: byte at address a is a[7:0]^8'h3C; odd byte on the upper lane.
    function automatic logic [7:0] mem_byte(logic [19:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction
    function automatic logic [15:0] mem_word(logic [19:0] a);
        return {mem_byte(a | 20'h1), mem_byte(a & ~20'h1)};
    endfunction

    assign bif.data_in = force_en ? force_val : mem_word(bif.address_out);

    bus_control_unit #(.QUEUE_DEPTH(8), .PREFETCH_MIN_FREE(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps       (ps),
        .flush    (flush),
        .flush_pc (flush_pc),
        .suspend  (suspend),
        .pop      (pop),
        .q_data   (q_data),
        .q_empty  (q_empty),
        .q_count  (q_count),
        .eu_cmd   (eu_cmd),
        .eu_addr  (eu_addr),
        .eu_wdata (eu_wdata),
        .eu_ube   (eu_ube),
        .eu_rdata (eu_rdata),
        .eu_done  (eu_done),
        .bus      (bif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic [19:0] a, input logic [3:0] st, input logic u, input logic [15:0] wd);
        bus_rec_t r;
        r.addr = a; r.st = st; r.ube = u; r.wd = wd;
        bus_q.push_back(r);
    endtask

    task automatic exp_b(input logic [7:0] b);
        byte_q.push_back(b);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_count(input int n);
        int k = 0;
        while (int'(q_count) != n && k < 100) begin @(posedge clk); #1; k++; end
        chk("count_reached", 32'(q_count), 32'(n));
    endtask

    task automatic wait_status(input logic [3:0] st);
        int k = 0;
        while (bif.bus_status !== st && k < 50) begin @(posedge clk); #1; k++; end
        chk("status_reached", 32'(bif.bus_status), 32'(st));
    endtask

    task automatic wait_done();
        int k = 0;
        while (eu_done !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        chk("eu_done_seen", 32'(eu_done), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(bif.address_out), 32'hFFFFF);
        chk({tag, "_status"}, 32'(bif.bus_status), 32'hF);
        chk({tag, "_ube"}, 32'(bif.bus_upper_byte_enable), 32'd0);
        chk({tag, "_dout"}, 32'(bif.data_out), 32'd0);
        chk({tag, "_rdata"}, 32'(eu_rdata), 32'd0);
        chk({tag, "_done"}, 32'(eu_done), 32'd0);
        chk({tag, "_empty"}, 32'(q_empty), 32'd1);
        chk({tag, "_count"}, 32'(q_count), 32'd0);
    endtask

    // Monitor: inputs are driven just after posedge, so at negedge they show
    // what the next posedge will sample.
    always @(negedge clk) begin
        bus_rec_t r;
        logic [7:0]  b;
        logic [15:0] d;
        if (reset) begin
            if (bif.bus_status !== 4'hF && bif.readyb === 1'b0) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got addr %h status %b", bif.address_out, bif.bus_status);
                end else begin
                    r = bus_q.pop_front();
                    chk("bus_addr", 32'(bif.address_out), 32'(r.addr));
                    chk("bus_status", 32'(bif.bus_status), 32'(r.st));
                    chk("bus_ube", 32'(bif.bus_upper_byte_enable), 32'(r.ube));
                    if (r.st == BUS_STATUS_MEM_WRITE || r.st == BUS_STATUS_IO_WRITE)
                        chk("bus_wdata", 32'(bif.data_out), 32'(r.wd));
                end
            end
            if (pop && !q_empty) begin
                if (byte_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL byte_unexpected: got %h", q_data);
                end else begin
                    b = byte_q.pop_front();
                    chk("q_data", 32'(q_data), 32'(b));
                end
            end
            if (eu_done) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL eu_done_unexpected: got rdata %h", eu_rdata);
                end else begin
                    d = rd_q.pop_front();
                    chk("eu_rdata", 32'(eu_rdata), 32'(d));
                end
            end
        end
    end

    initial begin
        ps = 16'hFFFF; flush_pc = 16'h0000; flush = 0; suspend = 0; pop = 0;
        eu_cmd = CMD_IDLE; eu_addr = '0; eu_wdata = '0; eu_ube = 0;
        bif.readyb = 0; force_en = 0; force_val = '0;
        #1 reset = 0;
        #11;
        chk_reset_outputs("reset");

        // Fill from FFFF0 until the 8-byte queue is full, then prefetch must stop.
        exp_bus(20'hFFFF0, 4'b1001, 1'b1, 16'h0); exp_bus(20'hFFFF2, 4'b1001, 1'b1, 16'h0);
        exp_bus(20'hFFFF4, 4'b1001, 1'b1, 16'h0); exp_bus(20'hFFFF6, 4'b1001, 1'b1, 16'h0);
        exp_b(8'hCC); exp_b(8'hCD); exp_b(8'hCE); exp_b(8'hCF);
        exp_b(8'hC8); exp_b(8'hC9); exp_b(8'hCA); exp_b(8'hCB);
        @(negedge clk) reset = 1;
        wait_count(8);
        cyc(4);
        chk("full_idle_status", 32'(bif.bus_status), 32'hF);
        chk("full_count", 32'(q_count), 32'd8);

        // Drain, with one extra pop on an empty queue.
        suspend = 1; pop = 1;
        cyc(9);
        pop = 0;
        chk("drain_count", 32'(q_count), 32'd0);
        chk("drain_empty", 32'(q_empty), 32'd1);

        // Odd flush target: single byte, then word-aligned fetches until free < 2.
`ifdef BCU_ODD_ALIGN_EN
        exp_bus(20'hFFFF3, 4'b1001, 1'b1, 16'h0);
`else
        exp_bus(20'hFFFF2, 4'b1001, 1'b1, 16'h0);
`endif
        exp_bus(20'hFFFF4, 4'b1001, 1'b1, 16'h0); exp_bus(20'hFFFF6, 4'b1001, 1'b1, 16'h0);
        exp_bus(20'hFFFF8, 4'b1001, 1'b1, 16'h0);
        exp_b(8'hCF); exp_b(8'hC8); exp_b(8'hC9); exp_b(8'hCA); exp_b(8'hCB);
        exp_b(8'hC4); exp_b(8'hC5);
        flush_pc = 16'h0003; flush = 1;
        cyc(1);
        flush = 0; suspend = 0;
        wait_count(7);
        cyc(4);
        chk("odd_idle_status", 32'(bif.bus_status), 32'hF);
        chk("odd_count", 32'(q_count), 32'd7);
        suspend = 1; pop = 1;
        cyc(7);
        pop = 0;
        chk("odd_drain_count", 32'(q_count), 32'd0);

        // EU write arrives while a prefetch (address wraps to 00000) is stalled.
        flush_pc = 16'h0010; flush = 1;
        cyc(1);
        flush = 0;
        exp_bus(20'h00000, 4'b1001, 1'b1, 16'h0);
        exp_bus(20'h00100, 4'b1010, 1'b1, 16'h1234);
        rd_q.push_back(16'h3D3C);
        exp_b(8'h3C); exp_b(8'h3D);
        bif.readyb = 1; suspend = 0;
        wait_status(4'b1001);
        eu_cmd = CMD_MEM_WRITE; eu_addr = 20'h00100; eu_wdata = 16'h1234; eu_ube = 1; suspend = 1;
        cyc(3);
        chk("pf_holds_bus", 32'(bif.bus_status), 32'b1001);
        bif.readyb = 0;
        wait_done();
        eu_cmd = CMD_IDLE;
        cyc(1);
        chk("done_one_pulse", 32'(eu_done), 32'd0);
        chk("eu_wr_count", 32'(q_count), 32'd2);
        pop = 1;
        cyc(2);
        pop = 0;

        // Flush while a prefetch is stalled: ABCD must be discarded.
        exp_bus(20'h00002, 4'b1001, 1'b1, 16'h0);
        force_en = 1; force_val = 16'hABCD;
        bif.readyb = 1; suspend = 0;
        wait_status(4'b1001);
        suspend = 1; flush_pc = 16'h0040; flush = 1;
        cyc(1);
        flush = 0;
        cyc(1);
        bif.readyb = 0;
        cyc(2);
        force_en = 0;
        chk("drain_discard_count", 32'(q_count), 32'd0);
        chk("drain_idle_status", 32'(bif.bus_status), 32'hF);
        exp_bus(20'h00030, 4'b1001, 1'b1, 16'h0);
        exp_b(8'h0C); exp_b(8'h0D);
        suspend = 0;
        wait_status(4'b1001);
        suspend = 1;
        wait_count(2);

        // One byte left, pop on the same edge as a 2-byte push.
        pop = 1;
        cyc(1);
        pop = 0;
        chk("one_left_count", 32'(q_count), 32'd1);
        exp_bus(20'h00032, 4'b1001, 1'b1, 16'h0);
        exp_b(8'h0E); exp_b(8'h0F);
        bif.readyb = 1; suspend = 0;
        wait_status(4'b1001);
        suspend = 1; pop = 1; bif.readyb = 0;
        cyc(1);
        pop = 0;
        chk("pop_push_count", 32'(q_count), 32'd2);
        pop = 1;
        cyc(2);
        pop = 0;
        chk("pop_push_drain", 32'(q_count), 32'd0);

        // IO read, lower lane only.
        exp_bus(20'h00100, 4'b0101, 1'b0, 16'h0);
        rd_q.push_back(16'h3D3C);
        eu_cmd = CMD_IO_READ; eu_addr = 20'h00100; eu_ube = 0;
        wait_done();
        eu_cmd = CMD_IDLE;
        cyc(1);

        // Reset asserted mid EU access.
        bif.readyb = 1; eu_cmd = CMD_MEM_READ; eu_addr = 20'h00200;
        wait_status(4'b1001);
        chk("eu_rd_addr", 32'(bif.address_out), 32'h00200);
        #2 reset = 0;
        #1 chk_reset_outputs("midreset");
        eu_cmd = CMD_IDLE; bif.readyb = 0;
        cyc(3);
        chk("midreset_no_done", 32'(eu_done), 32'd0);

        chk("bus_q_left", 32'(bus_q.size()), 32'd0);
        chk("byte_q_left", 32'(byte_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_control_unit.md
# bus_control_unit

Parametrised bus control unit (BCU) for the v30mz core: owns the external bus, an internal byte-wide prefetch queue of configurable depth, and arbitration between instruction prefetch and execution-unit (EU) memory/IO commands. Sits between the execution unit and the external pins, replacing the ad-hoc prefetch/bus logic in the top level. Handles queue flush on branches, odd-address alignment and suspend.

## Interface
- QUEUE_DEPTH, 8, queue capacity in bytes; power of two, ≥4
- PREFETCH_MIN_FREE, 2, free bytes required before a word prefetch starts
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- ps  in  16  program segment register
- flush  in  1  discard queue, restart fetch at flush_pc
- flush_pc  in  16  new program counter (offset within ps)
- suspend  in  1  inhibit new prefetch cycles
- pop  in  1  consume one byte from queue head
- q_data  out  8  queue head byte, valid when !q_empty
- q_empty  out  1  queue holds no bytes
- q_count  out  $clog2(QUEUE_DEPTH+1)  bytes held
- eu_cmd  in  3  bus_command_t: IDLE, MEM_READ, MEM_WRITE, IO_READ, IO_WRITE
- eu_addr  in  20  physical address for EU command
- eu_wdata  in  16  write data
- eu_ube  in  1  EU access uses upper byte lane
- eu_rdata  out  16  read data, valid in cycle eu_done=1
- eu_done  out  1  one-cycle pulse: EU command completed
- data_in  in  16  bus read data
- readyb  in  1  active-low bus ready
- address_out  out  20  bus address
- data_out  out  16  bus write data
- bus_status  out  4  1111 idle, 1001 mem read/prefetch, 1010 mem write, 0101 IO read, 0110 IO write
- bus_upper_byte_enable  out  1  upper lane active this bus cycle

## Operation
- States: IDLE, PREFETCH, EU_ACCESS, FLUSH_DRAIN.
- IDLE: eu_cmd≠IDLE → EU_ACCESS (EU has priority); else if !suspend and free ≥ PREFETCH_MIN_FREE (≥1 when PFP odd) → PREFETCH.
- PREFETCH: address_out={ps,4'h0}+{4'h0,PFP} (20-bit, carry above bit 19 dropped); bus_status=1001. On readyb=0: push 2 bytes (low first), PFP+=2; odd PFP: push data_in[15:8] only, PFP+=1. PFP wraps 16'hFFFF→0. Return to IDLE.
- EU_ACCESS: drive eu_addr, eu_wdata, eu_ube, status per eu_cmd. On readyb=0: eu_rdata<=data_in, eu_done pulses, → IDLE. EU command sampled at entry; changes mid-cycle ignored.
- In-flight prefetch always completes; EU command waits (eu_done only after its own cycle).
- flush in IDLE/EU_ACCESS: queue cleared, PFP<=flush_pc same edge. flush in PREFETCH: → FLUSH_DRAIN; cycle completes, data discarded, PFP<=flush_pc, → IDLE.
- pop on empty ignored. pop and push on same edge both take effect; q_count += pushed−popped. Push never exceeds capacity (guaranteed by free check).
- flush and pop on same edge: flush wins.

## Timing
- Reset values: state IDLE, queue empty, q_count 0, PFP 0, address_out 20'hFFFFF, bus_status 1111, bus_upper_byte_enable 0, data_out 0, eu_rdata 0, eu_done 0.
- Bus cycle minimum 2 clocks: 1 to enter state, ≥1 until readyb=0 sampled.
- Pushed bytes visible on q_data the cycle after the completing edge.
- q_data combinational from head pointer; pop effect visible next cycle.
- bus_status returns to 1111 in the cycle after completion unless a new cycle starts.

## Configuration
- BCU_ODD_ALIGN_EN defined: odd-PFP prefetch fetches single byte on upper lane (bus_upper_byte_enable=1, address odd), subsequent fetches word-aligned.
- Undefined: prefetch always fetches even-aligned word at PFP&~1; at odd PFP the low byte is discarded, one byte pushed, PFP+=1.

## Structure
- Package v30mz_pkg: bus_command_t enum, BUS_STATUS_* 4-bit constants, bcu_state_t.
- Submodule prefetch_fifo: byte FIFO with 0/1/2-byte push, 1-byte pop, clear, count; parametrised by QUEUE_DEPTH.

## Test plan
- Reset release, ps=16'hFFFF, flush_pc=16'h0000, readyb=0 always → first address_out 20'hFFFF0, queue fills to 8, prefetch stops.
- flush_pc=16'h0003 (odd, macro on) → address 20'hFFFF3, bus_upper_byte_enable=1, one byte pushed, next address 20'hFFFF4.
- eu_cmd=MEM_WRITE at 20'h00100 while prefetch waits readyb=1 for 3 clocks → prefetch completes first, then status 1010, eu_done one pulse.
- flush during prefetch with data 16'hABCD → bytes not in queue, next address uses flush_pc.
- pop every cycle with queue 1 byte and simultaneous 2-byte push → q_count 2, byte order preserved.
- reset asserted mid EU_ACCESS → all outputs at reset values immediately, no eu_done.
